// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame geometry
// that the baud generator and receiver must agree on.
package uart_rx_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int NB_DATA_DEF    = 8;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle (high) line level.
module uart_sync_2ff (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            meta <= 1'b1;
            o_q  <= 1'b1;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop deserialiser with a
// one-cycle done strobe and a framing-error flag held until the next frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] S_HALF  = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST  = N_W'(NB_DATA - 1);
    localparam logic [S_W-1:0] S_ONE   = S_W'(1);
    localparam logic [N_W-1:0] N_ONE   = N_W'(1);

    logic               rx_s;
    logic [1:0]         state;
    logic [S_W-1:0]     s;
    logic [N_W-1:0]     n;
    logic [NB_DATA-1:0] b;

    uart_sync_2ff u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Re-arms on any low level, so a held-low line yields repeated frames.
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s == S_HALF) begin
                            // Half-bit recheck rejects short glitches and sets the mid-bit sampling phase.
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s == S_BIT) begin
                            s <= '0;
                            b <= {rx_s, b[NB_DATA-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + N_ONE;
                            end
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (s == S_STOP) begin
                            o_data      <= b;
                            o_frame_err <= ~rx_s;
                            o_rx_done   <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, single frame timing, glitch rejection,
// framing error, back-to-back frames and reset in the middle of a frame.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       clk;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    int checks = 0;
    int errors = 0;

    int tick_total = 0;
    int done_cnt   = 0;
    int done_tick  = 0;
    logic [7:0] done_data = '0;
    logic       done_err  = 1'b0;
    logic       prev_done = 1'b0;
    int consec_cnt = 0;
    int tick_div   = 0;

    uart_rx dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clocks, changed on the falling edge
    initial begin
        i_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            i_tick = (tick_div == 3);
        end
    end

    always @(posedge clk) begin
        if (i_tick) tick_total <= tick_total + 1;
    end

    always @(negedge clk) begin
        prev_done <= (o_rx_done === 1'b1);
        if (o_rx_done === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            done_tick <= tick_total;
            done_data <= o_data;
            done_err  <= o_frame_err;
            if (prev_done) consec_cnt <= consec_cnt + 1;
        end
    end

    task automatic wait_ticks(input int k);
        repeat (k) begin
            @(posedge clk);
            while (!i_tick) @(posedge clk);
        end
    endtask

    // Must be called right after a tick edge; returns right after the last stop tick.
    task automatic send_frame(input logic [7:0] d, input bit stop_low, output int base);
        @(negedge clk);
        base = tick_total;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_rx = d[i];
            wait_ticks(16);
        end
        @(negedge clk);
        i_rx = stop_low ? 1'b0 : 1'b1;
        wait_ticks(8);
        @(negedge clk);
        i_rx = 1'b1;
        wait_ticks(8);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
        checks++; if (o_rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_rx_done); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", o_frame_err); end
        i_reset = 1'b0;
        wait_ticks(200);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reset_idle_done: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_single();
        int base;
        int c0;
        c0 = done_cnt;
        send_frame(8'hA5, 1'b0, base);
        wait_ticks(4);
        checks++; if (done_cnt !== c0 + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", done_cnt - c0, 1); end
        checks++; if (done_tick - base !== 152) begin errors++; $display("FAIL single_latency: got %0d ticks expected 152", done_tick - base); end
        checks++; if (done_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", done_data); end
        checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL single_ferr: got %b expected 0", done_err); end
    endtask

    task automatic test_glitch();
        int base;
        int c0;
        c0 = done_cnt;
        @(negedge clk);
        i_rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        i_rx = 1'b1;
        wait_ticks(30);
        checks++; if (done_cnt !== c0) begin errors++; $display("FAIL glitch_done: got %0d expected 0", done_cnt - c0); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE); end
        send_frame(8'h3C, 1'b0, base);
        wait_ticks(4);
        checks++; if (done_cnt !== c0 + 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", done_cnt - c0); end
        checks++; if (done_data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data: got %h expected 3c", done_data); end
    endtask

    task automatic test_frame_err();
        int base;
        send_frame(8'h00, 1'b1, base);
        wait_ticks(30);
        checks++; if (done_data !== 8'h00) begin errors++; $display("FAIL ferr_data: got %h expected 00", done_data); end
        checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", done_err); end
        send_frame(8'h55, 1'b0, base);
        wait_ticks(4);
        checks++; if (done_data !== 8'h55) begin errors++; $display("FAIL ferr_next_data: got %h expected 55", done_data); end
        checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b expected 0", done_err); end
    endtask

    task automatic test_back_to_back();
        int base;
        int c0;
        int t1;
        logic [7:0] d1;
        logic       e1;
        c0 = done_cnt;
        send_frame(8'h01, 1'b0, base);
        t1 = done_tick;
        d1 = done_data;
        e1 = done_err;
        send_frame(8'hFF, 1'b0, base);
        wait_ticks(4);
        checks++; if (done_cnt !== c0 + 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", done_cnt - c0); end
        checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL b2b_data1: got %h expected 01", d1); end
        checks++; if (done_data !== 8'hFF) begin errors++; $display("FAIL b2b_data2: got %h expected ff", done_data); end
        checks++; if (done_tick - t1 !== 160) begin errors++; $display("FAIL b2b_spacing: got %0d ticks expected 160", done_tick - t1); end
        checks++; if ((e1 | done_err) !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b/%b expected 0/0", e1, done_err); end
    endtask

    task automatic test_reset_mid();
        int base;
        int c0;
        logic [7:0] d;
        d  = 8'h96;
        c0 = done_cnt;
        @(negedge clk);
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_rx = d[i];
            wait_ticks(16);
        end
        @(negedge clk);
        i_rx = d[3];
        wait_ticks(5);
        @(negedge clk);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", o_data); end
        checks++; if (o_rx_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", o_rx_done); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b expected 0", o_frame_err); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state, IDLE); end
        wait_ticks(200);
        checks++; if (done_cnt !== c0) begin errors++; $display("FAIL rstmid_nodone: got %0d expected 0", done_cnt - c0); end
        send_frame(8'h96, 1'b0, base);
        wait_ticks(4);
        checks++; if (done_data !== 8'h96) begin errors++; $display("FAIL rstmid_next_data: got %h expected 96", done_data); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_rx    = 1'b1;
        test_reset();
        wait_ticks(1);
        test_single();
        test_glitch();
        test_frame_err();
        wait_ticks(10);
        test_back_to_back();
        test_reset_mid();
        checks++; if (consec_cnt !== 0) begin errors++; $display("FAIL done_consecutive: got %0d expected 0", consec_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
